// File: rtl/vec_alu_unit.sv
// ---------------------------------------------------------------------------
// vec_alu_unit
//
// Single-lane 32-bit arithmetic / pixel operator for the vector execute stage.
// One instance per vector lane.
//
// Ports
//   clk     in   1   rising-edge clock, used only by the output register
//   rst_n   in   1   synchronous active-low reset (clears out_q only)
//   VCSub   in   1   subtract / variant select
//   ALUop   in   3   opcode
//   inputA  in  32   operand A
//   inputB  in  32   operand B
//   Vx      in  16   lane-condition word: lo = Vx[7:0], hi = Vx[15:8]
//   c7      in   8   unsigned scalar constant
//   out     out 32   combinational result (same-cycle writeback path)
//   out_q   out 32   registered copy of out (1-cycle pipelined path)
//
// Opcodes
//   000 vadd  A + B, or A - B when VCSub = 1
//   001 vopg  conditional pixel generate (8-bit result, zero-extended)
//   010 vopa  A, or A - c7 when VCSub = 1
//   011 vsub  A - B
//   100 vmul  low word of A * B (only with VECALU_MUL_EN, otherwise 0)
//   101 and   A & B
//   110 or    A | B
//   111 xor   A ^ B
//
// Build option
//   VECALU_MUL_EN  when defined, a 32x32 multiplier serves opcode 100.
//                  When undefined no multiplier exists and opcode 100 gives 0.
// ---------------------------------------------------------------------------
module vec_alu_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        VCSub,
   input  logic [2:0]  ALUop,
   input  logic [31:0] inputA,
   input  logic [31:0] inputB,
   input  logic [15:0] Vx,
   input  logic [7:0]  c7,
   output logic [31:0] out,
   output logic [31:0] out_q
);

   // ------------------------------------------------------------------------
   // Opcode encoding
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      OP_VADD = 3'b000,
      OP_VOPG = 3'b001,
      OP_VOPA = 3'b010,
      OP_VSUB = 3'b011,
      OP_VMUL = 3'b100,
      OP_AND  = 3'b101,
      OP_OR   = 3'b110,
      OP_XOR  = 3'b111
   } alu_op_e;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // Saturating 10*c: the product needs 12 bits (10*255 = 2550), clamp to 255.
   function automatic logic [7:0] sat_times10(input logic [7:0] c);
      logic [11:0] prod;
      // 10*c built as 8*c + 2*c to keep it a pair of shifts and one adder.
      prod = {1'b0, c, 3'b000} + {3'b000, c, 1'b0};
      if (prod > 12'd255) begin
         return 8'hFF;
      end
      return prod[7:0];
   endfunction

   // Unsigned 8-bit remainder, unrolled restoring division.
   // The partial remainder is always below den (<= 255) before each shift,
   // so after shifting in the next numerator bit it fits in 9 bits.
   // A zero divisor returns the numerator unchanged.
   function automatic logic [7:0] rem8(input logic [7:0] num,
                                       input logic [7:0] den);
      logic [8:0] r;
      if (den == 8'd0) begin
         return num;
      end
      r = 9'd0;
      for (int i = 7; i >= 0; i--) begin
         r = {r[7:0], num[i]};
         if (r >= {1'b0, den}) begin
            r = r - {1'b0, den};
         end
      end
      return r[7:0];
   endfunction

   // Conditional pixel generate, selected by the two byte flags of Vx.
   function automatic logic [7:0] pixel_gen(input logic       flag_lo,
                                            input logic       flag_hi,
                                            input logic [7:0] a_lo,
                                            input logic [7:0] c);
      logic [1:0] sel;
      sel = {flag_hi, flag_lo};
      unique case (sel)
         2'b11:   return 8'hFF;
         2'b10:   return sat_times10(c);
         2'b01:   return rem8(a_lo, c);
         default: return 8'h00;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Condition flags
   // ------------------------------------------------------------------------
   logic [7:0] vx_lo;
   logic [7:0] vx_hi;
   logic       fl;
   logic       fh;

   assign vx_lo = Vx[7:0];
   assign vx_hi = Vx[15:8];
   assign fl    = (vx_lo == 8'hFF);
   assign fh    = (vx_hi == 8'hFF);

   // ------------------------------------------------------------------------
   // Shared operand datapaths
   // ------------------------------------------------------------------------
   logic [31:0] sum_ab;
   logic [31:0] diff_ab;
   logic [31:0] diff_ac;
   logic [31:0] c7_ext;
   logic [7:0]  pix;
   logic [31:0] mul_lo;

   assign c7_ext  = {24'b0, c7};
   assign sum_ab  = inputA + inputB;
   // vadd with VCSub and vsub both use this single subtractor.
   assign diff_ab = inputA - inputB;
   assign diff_ac = inputA - c7_ext;
   assign pix     = pixel_gen(fl, fh, inputA[7:0], c7);

`ifdef VECALU_MUL_EN
   // Only the low word is kept; the upper 32 product bits are never formed.
   assign mul_lo = inputA * inputB;
`else
   assign mul_lo = 32'h0;
`endif

   // ------------------------------------------------------------------------
   // Result select (combinational out)
   // ------------------------------------------------------------------------
   alu_op_e op;
   assign op = alu_op_e'(ALUop);

   always_comb begin
      out = 32'h0;
      unique case (op)
         OP_VADD: out = VCSub ? diff_ab : sum_ab;
         OP_VOPG: out = {24'b0, pix};
         OP_VOPA: out = VCSub ? diff_ac : inputA;
         OP_VSUB: out = diff_ab;
         OP_VMUL: out = mul_lo;
         OP_AND:  out = inputA & inputB;
         OP_OR:   out = inputA | inputB;
         OP_XOR:  out = inputA ^ inputB;
         default: out = 32'h0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output register (1-cycle copy of out)
   // ------------------------------------------------------------------------
   logic [31:0] res_d;
   logic [31:0] res_q;

   always_comb begin
      res_d = out;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= 32'h0;
      end else begin
         res_q <= res_d;
      end
   end

   assign out_q = res_q;

endmodule

// File: tb/tb_vec_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_alu_unit
//
// Self-checking bench for vec_alu_unit. Expected results are produced by an
// independent behavioural model, pushed into a scoreboard queue when the
// stimulus is driven and popped when the DUT output is sampled.
// Build with +define+VECALU_MUL_EN to exercise the multiplier build.
// ---------------------------------------------------------------------------
module tb_vec_alu_unit;

   logic        clk;
   logic        rst_n;
   logic        VCSub;
   logic [2:0]  ALUop;
   logic [31:0] inputA;
   logic [31:0] inputB;
   logic [15:0] Vx;
   logic [7:0]  c7;
   logic [31:0] out;
   logic [31:0] out_q;

   int n_pass;
   int n_total;

   logic [31:0] sb_q[$];

   vec_alu_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .VCSub  (VCSub),
      .ALUop  (ALUop),
      .inputA (inputA),
      .inputB (inputB),
      .Vx     (Vx),
      .c7     (c7),
      .out    (out),
      .out_q  (out_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the run is short; anything beyond this is a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
      $fatal(1, "timeout");
   end

   // Independent reference model of the operator.
   function automatic logic [31:0] model(input logic        vcsub,
                                         input logic [2:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [15:0] vx,
                                         input logic [7:0]  c);
      int t;
      logic fl;
      logic fh;
      fl = (vx[7:0] == 8'hFF);
      fh = (vx[15:8] == 8'hFF);
      case (op)
         3'd0: return vcsub ? (a - b) : (a + b);
         3'd1: begin
            if (fl && fh) t = 255;
            else if (fh) begin
               t = 10 * int'(c);
               if (t > 255) t = 255;
            end else if (fl) begin
               if (c == 8'd0) t = int'(a[7:0]);
               else t = int'(a[7:0]) % int'(c);
            end else t = 0;
            return 32'(t);
         end
         3'd2: return vcsub ? (a - {24'b0, c}) : a;
         3'd3: return a - b;
         3'd4: begin
`ifdef VECALU_MUL_EN
            logic [63:0] p;
            p = {32'b0, a} * {32'b0, b};
            return p[31:0];
`else
            return 32'h0;
`endif
         end
         3'd5: return a & b;
         3'd6: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // Drive one operation and push the model's expected result.
   task automatic drive(input logic        vcsub,
                        input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [15:0] vx,
                        input logic [7:0]  c);
      VCSub  = vcsub;
      ALUop  = op;
      inputA = a;
      inputB = b;
      Vx     = vx;
      c7     = c;
      sb_q.push_back(model(vcsub, op, a, b, vx, c));
   endtask

   // Directed table for the combinational path.
   typedef struct {
      logic        vcsub;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] vx;
      logic [7:0]  c;
      logic [31:0] req;
      string       name;
   } vec_t;

   task automatic test_reset();
      logic [31:0] got;
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 3'd7, 32'hDEADBEEF, 32'h12345678, 16'h1234, 8'h55);
      void'(sb_q.pop_back());
      sb_q.push_back(32'h0);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      n_total++;
      if (out_q !== got) $display("FAIL reset_out_q: got %h required %h", out_q, got);
      else n_pass++;
   endtask

   task automatic test_directed();
      vec_t tbl[$];
      logic [31:0] exp_v;
      tbl.push_back('{1'b0, 3'd1, 32'd100, 32'd103, 16'hFFFF, 8'd25, 32'd255, "vopg_both"});
      tbl.push_back('{1'b0, 3'd2, 32'd100, 32'd103, 16'hFFFF, 8'd25, 32'd100, "vopa_pass"});
      tbl.push_back('{1'b0, 3'd2, 32'd101, 32'd0,   16'hFF00, 8'd25, 32'd101, "vopa_pass2"});
      tbl.push_back('{1'b0, 3'd1, 32'd101, 32'd0,   16'hFF00, 8'd25, 32'd250, "vopg_x10"});
      tbl.push_back('{1'b0, 3'd1, 32'd101, 32'd0,   16'hFF00, 8'd30, 32'd255, "vopg_sat"});
      tbl.push_back('{1'b1, 3'd1, 32'd101, 32'd0,   16'hFF00, 8'd30, 32'd255, "vopg_vcsub"});
      tbl.push_back('{1'b0, 3'd1, 32'd102, 32'd0,   16'h00FF, 8'd25, 32'd2,   "vopg_mod"});
      tbl.push_back('{1'b0, 3'd1, 32'd102, 32'd0,   16'h00FF, 8'd0,  32'd102, "vopg_mod0"});
      tbl.push_back('{1'b0, 3'd1, 32'd102, 32'd0,   16'h0000, 8'd0,  32'd0,   "vopg_none"});
      tbl.push_back('{1'b0, 3'd2, 32'd102, 32'd0,   16'h0000, 8'd0,  32'd102, "vopa_pass3"});
      tbl.push_back('{1'b0, 3'd1, 32'h1FF, 32'd0,   16'h00FF, 8'd7,  32'd3,   "vopg_mod_alo"});
      tbl.push_back('{1'b1, 3'd0, 32'd5,   32'd7,   16'h0000, 8'd0,  32'hFFFFFFFE, "vadd_sub"});
      tbl.push_back('{1'b0, 3'd0, 32'hFFFFFFFF, 32'd2, 16'h0000, 8'd0, 32'd1, "vadd_wrap"});
      tbl.push_back('{1'b1, 3'd2, 32'd5,   32'd7,   16'hFFFF, 8'd25, 32'hFFFFFFEC, "vopa_subc"});
      tbl.push_back('{1'b1, 3'd3, 32'd5,   32'd7,   16'h0000, 8'd0,  32'hFFFFFFFE, "vsub"});
      tbl.push_back('{1'b0, 3'd5, 32'd5,   32'd7,   16'h0000, 8'd0,  32'd5,   "and"});
      tbl.push_back('{1'b0, 3'd6, 32'd5,   32'd8,   16'h0000, 8'd0,  32'd13,  "or"});
      tbl.push_back('{1'b0, 3'd7, 32'd5,   32'd7,   16'h0000, 8'd0,  32'd2,   "xor"});
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].vcsub, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].vx, tbl[i].c);
         #1;
         exp_v = sb_q.pop_front();
         n_total++;
         if (out !== tbl[i].req || out !== exp_v)
            $display("FAIL %s: got %h required %h (model %h)", tbl[i].name, out, tbl[i].req, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_vmul();
      logic [31:0] req;
      logic [31:0] exp_v;
`ifdef VECALU_MUL_EN
      req = 32'h10000;
`else
      req = 32'h0;
`endif
      @(negedge clk);
      drive(1'b0, 3'd4, 32'h10000, 32'h10001, 16'h0000, 8'd0);
      #1;
      exp_v = sb_q.pop_front();
      n_total++;
      if (out !== req || out !== exp_v)
         $display("FAIL vmul: got %h required %h", out, req);
      else n_pass++;
   endtask

   task automatic test_register_path();
      logic [31:0] exp_v;
      // Reset held for one edge.
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if (out_q !== 32'h0) $display("FAIL regpath_reset: got %h required %h", out_q, 32'h0);
      else n_pass++;
      // Release and apply case 1.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 3'd1, 32'd100, 32'd103, 16'hFFFF, 8'd25);
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      n_total++;
      if (out_q !== exp_v || out_q !== 32'd255)
         $display("FAIL regpath_capture: got %h required %h", out_q, 32'd255);
      else n_pass++;
      // Mid-stream reset: out_q clears, out keeps its value.
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if (out_q !== 32'h0) $display("FAIL regpath_midreset_q: got %h required %h", out_q, 32'h0);
      else n_pass++;
      n_total++;
      if (out !== 32'd255) $display("FAIL regpath_midreset_out: got %h required %h", out, 32'd255);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_v;
      logic [15:0] vx_sel[4];
      logic [15:0] vx_r;
      vx_sel[0] = 16'hFFFF;
      vx_sel[1] = 16'hFF00;
      vx_sel[2] = 16'h00FF;
      vx_sel[3] = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         vx_r = (i % 5 == 4) ? 16'($urandom) : vx_sel[$urandom_range(0, 3)];
         drive(1'($urandom), 3'($urandom), $urandom, $urandom, vx_r, 8'($urandom));
         #1;
         // Combinational result against the most recent expectation.
         n_total++;
         if (out !== sb_q[sb_q.size() - 1])
            $display("FAIL b2b_out[%0d]: got %h required %h", i, out, sb_q[sb_q.size() - 1]);
         else n_pass++;
         @(posedge clk);
         #1;
         exp_v = sb_q.pop_front();
         n_total++;
         if (out_q !== exp_v)
            $display("FAIL b2b_out_q[%0d]: got %h required %h", i, out_q, exp_v);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      VCSub   = 1'b0;
      ALUop   = 3'd0;
      inputA  = 32'h0;
      inputB  = 32'h0;
      Vx      = 16'h0;
      c7      = 8'h0;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_directed();
      test_vmul();
      test_register_path();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
